// File: rtl/cb_mult_pkg.sv
// Shared definitions for the two-requester column-bypass multiplier arbiter.
package cb_mult_pkg;

  localparam int unsigned DEF_M      = 4;
  localparam int unsigned DEF_N      = 4;
  localparam int unsigned DEF_SETTLE = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/ArrayMultiplier_column_bypass_generic.sv
// Unsigned m x n array multiplier; columns with a[i]==0 skip the partial-product adder.
module ArrayMultiplier_column_bypass_generic #(
  parameter int m = 4,
  parameter int n = 4
) (
  output logic [m+n-1:0] p,
  input  logic [m-1:0]   a,
  input  logic [n-1:0]   x
);

  // Row-by-row ripple array; a zero multiplicand bit turns its column into a pass-through half adder
  always_comb begin
    logic [m+n-1:0] acc;
    logic           c;
    logic           s;
    acc = '0;
    c   = 1'b0;
    s   = 1'b0;
    for (int j = 0; j < n; j++) begin
      c = 1'b0;
      for (int i = 0; i < m; i++) begin
        s = acc[i+j];
        if (a[i]) begin
          acc[i+j] = s ^ x[j] ^ c;
          c        = (s & x[j]) | (c & (s ^ x[j]));
        end else begin
          acc[i+j] = s ^ c;
          c        = s & c;
        end
      end
      acc[j+m] = c;
    end
    p = acc;
  end

endmodule

// File: rtl/cb_mult_arbiter.sv
// Round-robin arbiter sharing one column-bypass array multiplier between two requesters.
module cb_mult_arbiter
  import cb_mult_pkg::*;
#(
  parameter int unsigned M      = DEF_M,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [M-1:0] req0_a,
  input  logic [N-1:0] req0_x,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [M-1:0] req1_a,
  input  logic [N-1:0] req1_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [M+N-1:0] rsp_p
);

  localparam int unsigned P_W = M + N;

  state_e           state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [N-1:0]     x_q, x_d;
  logic             id_q, id_d;
  logic [P_W-1:0]   p_q, p_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  logic             grant_c;
  logic             accept_c;
  logic [M-1:0]     in_a_c;
  logic [N-1:0]     in_x_c;
  logic             zero_c;
  logic             settled_c;
  logic [P_W-1:0]   arr_p;

  // Grant req1 when it is alone, or on a tie when req0 was served last
  assign grant_c   = req1_valid & (~req0_valid | ~last_q);
  assign accept_c  = (state_q == ST_IDLE) & ~rst & (req0_valid | req1_valid);
  assign in_a_c    = grant_c ? req1_a : req0_a;
  assign in_x_c    = grant_c ? req1_x : req0_x;
  assign zero_c    = (in_a_c == '0) | (in_x_c == '0);
  assign settled_c = (cnt_q == CNT_W'(SETTLE - 1));

  ArrayMultiplier_column_bypass_generic #(
    .m(M),
    .n(N)
  ) u_mult (
    .p(arr_p),
    .a(a_q),
    .x(x_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: zero operands skip the array and go straight to RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_c) state_d = zero_c ? ST_RESP : ST_COMPUTE;
      ST_COMPUTE: if (settled_c) state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request handshake: ready only in IDLE, only for the granted valid requester
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      req0_ready = req0_valid & ~grant_c;
      req1_ready = req1_valid & grant_c;
    end
  end

  // Datapath next values; operand registers move only on an accepted non-zero request
  always_comb begin
    a_d    = a_q;
    x_d    = x_q;
    id_d   = id_q;
    p_d    = p_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          id_d   = grant_c;
          last_d = grant_c;
          cnt_d  = '0;
          if (zero_c) begin
            p_d   = '0;
            vld_d = 1'b1;
          end else begin
            a_d = in_a_c;
            x_d = in_x_c;
          end
        end
      end
      ST_COMPUTE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (settled_c) begin
          p_d   = arr_p;
          vld_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) vld_d = 1'b0;
      end
      default: begin
        vld_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      x_q    <= '0;
      id_q   <= 1'b0;
      p_q    <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      a_q    <= a_d;
      x_q    <= x_d;
      id_q   <= id_d;
      p_q    <= p_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_p     = p_q;

endmodule
